// File: rtl/gamepad_pkg.sv
// Shared definitions for the SNES-style gamepad reader: FSM states, frame
// size, button bit positions and the frame-to-button mapping helper.
package gamepad_pkg;

  localparam int FRAME_BITS = 16;

  // Button positions inside the committed button word (LSB first on the wire)
  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  typedef enum logic [2:0] {
    ST_LATCH    = 3'd0,
    ST_SHIFT_LO = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_DONE     = 3'd3,
    ST_WAIT     = 3'd4
  } gp_state_e;

  // Pad lines are active-low; an all-low frame means no pad is attached,
  // which must read as "nothing pressed" rather than "everything pressed".
  function automatic logic [FRAME_BITS-1:0] raw_to_buttons(input logic [FRAME_BITS-1:0] raw);
    logic [FRAME_BITS-1:0] btn;
    if (raw == {FRAME_BITS{1'b0}}) begin
      btn = {FRAME_BITS{1'b0}};
    end else begin
      btn = ~raw;
    end
    return btn;
  endfunction

endpackage

// File: rtl/gamepad_reader_if.sv
// Pad-side and consumer-side signals of the gamepad reader. The master
// modport is the reader itself; the slave modport is the pad/consumer side.
interface gamepad_reader_if;
  import gamepad_pkg::*;

  logic                  pad_data;
  logic                  pad_latch;
  logic                  pad_clk;
  logic [FRAME_BITS-1:0] buttons;
  logic                  buttons_valid;
  logic                  pad_present;

  modport master (
    input  pad_data,
    output pad_latch, pad_clk, buttons, buttons_valid, pad_present
  );

  modport slave (
    output pad_data,
    input  pad_latch, pad_clk, buttons, buttons_valid, pad_present
  );

endinterface

// File: rtl/gamepad_sync.sv
// Two-flop synchroniser for the asynchronous pad data line. Resets to 1,
// the released (not pressed) level of the line.
module gamepad_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // Shift the asynchronous input through two flops
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/gamepad_reader.sv
// SNES-style gamepad serial reader. Latches the pad, clocks out 16 bits LSB
// first, and commits an active-high button word with a one-cycle strobe.
// Optional build macro GAMEPAD_DEBOUNCE_EN: commit only when two consecutive
// raw frames agree.
module gamepad_reader
  import gamepad_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int POLL_PERIOD = 200
) (
  input  logic             clk,
  input  logic             rst,
  gamepad_reader_if.master pad_if
);

  localparam int CNT_W  = $clog2(2 * CLK_DIV);
  localparam int POLL_W = $clog2(POLL_PERIOD);
  localparam int BIT_W  = $clog2(FRAME_BITS);

  localparam logic [CNT_W-1:0]  HALF_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  LATCH_LAST = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_PERIOD - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(FRAME_BITS - 1);

  gp_state_e             state_q, state_d;
  logic [CNT_W-1:0]      phase_q, phase_d;
  logic [POLL_W-1:0]     poll_q, poll_d;
  logic [BIT_W-1:0]      bit_idx_q, bit_idx_d;
  logic [FRAME_BITS-1:0] raw_q;
  logic [FRAME_BITS-1:0] buttons_q;
  logic                  pad_latch_q, pad_clk_q, valid_q, present_q;
  logic                  data_sync_s, sample_s, frame_ok_s, commit_s;

  gamepad_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (pad_if.pad_data),
    .q_o (data_sync_s)
  );

  // Sample on the last cycle of the low phase, after the synchroniser settled
  assign sample_s = (state_q == ST_SHIFT_LO) && (phase_q == HALF_LAST);

`ifdef GAMEPAD_DEBOUNCE_EN
  logic [FRAME_BITS-1:0] prev_raw_q;

  assign frame_ok_s = (raw_q == prev_raw_q);

  // Remember every completed raw frame, committed or not
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_raw_q <= {FRAME_BITS{1'b0}};
    end else if (state_q == ST_DONE) begin
      prev_raw_q <= raw_q;
    end else begin
      prev_raw_q <= prev_raw_q;
    end
  end
`else
  assign frame_ok_s = 1'b1;
`endif

  assign commit_s = (state_q == ST_DONE) && frame_ok_s;

  // Next-state and counter logic for the latch/shift/wait sequence
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q + CNT_W'(1);
    poll_d    = poll_q + POLL_W'(1);
    bit_idx_d = bit_idx_q;
    case (state_q)
      ST_LATCH: begin
        if (phase_q == LATCH_LAST) begin
          state_d   = ST_SHIFT_LO;
          phase_d   = {CNT_W{1'b0}};
          bit_idx_d = {BIT_W{1'b0}};
        end else begin
          state_d = ST_LATCH;
        end
      end
      ST_SHIFT_LO: begin
        if (phase_q == HALF_LAST) begin
          state_d = ST_SHIFT_HI;
          phase_d = {CNT_W{1'b0}};
        end else begin
          state_d = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_HI: begin
        if (phase_q == HALF_LAST) begin
          phase_d = {CNT_W{1'b0}};
          if (bit_idx_q == BIT_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_SHIFT_LO;
            bit_idx_d = bit_idx_q + BIT_W'(1);
          end
        end else begin
          state_d = ST_SHIFT_HI;
        end
      end
      ST_DONE: begin
        state_d = ST_WAIT;
        phase_d = {CNT_W{1'b0}};
      end
      ST_WAIT: begin
        phase_d = {CNT_W{1'b0}};
        if (poll_q == POLL_LAST) begin
          state_d = ST_LATCH;
          poll_d  = {POLL_W{1'b0}};
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_WAIT;
        phase_d = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and counters; reset parks in WAIT so the latch fires right after release
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_WAIT;
      phase_q   <= {CNT_W{1'b0}};
      poll_q    <= POLL_LAST;
      bit_idx_q <= {BIT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      poll_q    <= poll_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  // Pad control lines registered from the next state, plus raw frame capture
  always_ff @(posedge clk) begin
    if (rst) begin
      pad_latch_q <= 1'b0;
      pad_clk_q   <= 1'b1;
      raw_q       <= {FRAME_BITS{1'b0}};
    end else begin
      pad_latch_q <= (state_d == ST_LATCH);
      pad_clk_q   <= (state_d != ST_SHIFT_LO);
      if (sample_s) begin
        raw_q[bit_idx_q] <= data_sync_s;
      end else begin
        raw_q <= raw_q;
      end
    end
  end

  // Commit the finished frame and pulse the valid strobe alongside it
  always_ff @(posedge clk) begin
    if (rst) begin
      buttons_q <= {FRAME_BITS{1'b0}};
      present_q <= 1'b0;
      valid_q   <= 1'b0;
    end else if (commit_s) begin
      buttons_q <= raw_to_buttons(raw_q);
      present_q <= (raw_q != {FRAME_BITS{1'b0}});
      valid_q   <= 1'b1;
    end else begin
      buttons_q <= buttons_q;
      present_q <= present_q;
      valid_q   <= 1'b0;
    end
  end

  assign pad_if.pad_latch     = pad_latch_q;
  assign pad_if.pad_clk       = pad_clk_q;
  assign pad_if.buttons       = buttons_q;
  assign pad_if.buttons_valid = valid_q;
  assign pad_if.pad_present   = present_q;

endmodule

// File: tb/tb_gamepad_reader.sv
// Self-checking bench for gamepad_reader: a behavioural pad shift register,
// a frame-level reference model and randomized frame contents.
module tb_gamepad_reader;
  import gamepad_pkg::*;

  localparam int CLK_DIV    = 4;
  localparam int POLL       = 200;
  localparam int LATCH_LEN  = 2 * CLK_DIV;
  localparam int STROBE_OFS = 34 * CLK_DIV + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  gamepad_reader_if gp_if ();

  gamepad_reader #(.CLK_DIV(CLK_DIV), .POLL_PERIOD(POLL)) dut (
    .clk    (clk),
    .rst    (rst),
    .pad_if (gp_if)
  );

  // Pad model: parallel load on latch, shift towards bit 0 on each clock rise
  logic [15:0] pad_frame = 16'hFFFF;
  logic [15:0] pad_sh    = 16'hFFFF;
  assign gp_if.pad_data = pad_sh[0];

  always @(posedge gp_if.pad_latch or posedge gp_if.pad_clk) begin
    if (gp_if.pad_latch) pad_sh = pad_frame;
    else                 pad_sh = {1'b0, pad_sh[15:1]};
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] m_buttons = 16'h0000;
  logic        m_present = 1'b0;
  logic [15:0] m_prev_raw = 16'h0000;
  bit          have_prev = 1'b0;
  int          last_t0 = 0;
  int          last_wait = 0;
  logic        lat_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_reset_values();
    check_eq("rst_latch",   gp_if.pad_latch,     1'b0);
    check_eq("rst_padclk",  gp_if.pad_clk,       1'b1);
    check_eq("rst_buttons", gp_if.buttons,       16'h0000);
    check_eq("rst_valid",   gp_if.buttons_valid, 1'b0);
    check_eq("rst_present", gp_if.pad_present,   1'b0);
  endtask

  // Wait (bounded) for a latch rising edge seen at the falling clock edge
  task automatic wait_latch_rise(output bit found);
    int n;
    found = 1'b0;
    n = 0;
    while (!found && n < 300) begin
      @(negedge clk);
      n++;
      if (gp_if.pad_latch && !lat_prev) found = 1'b1;
      lat_prev = gp_if.pad_latch;
    end
    last_wait = n;
    check_eq("latch_seen", found, 1'b1);
  endtask

  // One full poll period with the pad presenting raw frame 'raw'
  task automatic run_frame(input logic [15:0] raw);
    bit   found, exp_strobe;
    int   t0, lat_cnt, falls, bad_falls, vcnt;
    logic clk_prev;
    pad_frame = raw;
`ifdef GAMEPAD_DEBOUNCE_EN
    exp_strobe = (raw == m_prev_raw);
`else
    exp_strobe = 1'b1;
`endif
    m_prev_raw = raw;
    if (exp_strobe) begin
      m_present = (raw != 16'h0000);
      m_buttons = m_present ? (16'hFFFF ^ raw) : 16'h0000;
    end
    wait_latch_rise(found);
    if (!found) return;
    t0 = cyc;
    if (have_prev) check_eq("poll_spacing", t0 - last_t0, POLL);
    have_prev = 1'b1;
    last_t0   = t0;
    lat_cnt = 1; falls = 0; bad_falls = 0; vcnt = 0;
    clk_prev = gp_if.pad_clk;
    for (int k = 1; k < POLL; k++) begin
      @(negedge clk);
      if (gp_if.pad_latch) lat_cnt++;
      if (clk_prev && !gp_if.pad_clk) begin
        falls++;
        if (gp_if.pad_latch) bad_falls++;
      end
      clk_prev = gp_if.pad_clk;
      lat_prev = gp_if.pad_latch;
      if (gp_if.buttons_valid) begin
        vcnt++;
        check_eq("strobe_time", cyc - t0, STROBE_OFS);
        check_eq("strobe_buttons", gp_if.buttons, m_buttons);
        check_eq("strobe_present", gp_if.pad_present, m_present);
      end
    end
    check_eq("latch_width", lat_cnt, LATCH_LEN);
    check_eq("padclk_falls", falls, 16);
    check_eq("falls_in_latch", bad_falls, 0);
    check_eq("strobe_count", vcnt, exp_strobe ? 1 : 0);
    check_eq("hold_buttons", gp_if.buttons, m_buttons);
    check_eq("hold_present", gp_if.pad_present, m_present);
  endtask

  // Start a frame, then reset part-way through it for three cycles
  task automatic abort_frame(input logic [15:0] raw);
    bit found;
    int vcnt;
    pad_frame = raw;
    wait_latch_rise(found);
    vcnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (gp_if.buttons_valid) vcnt++;
    end
    check_eq("abort_no_early_strobe", vcnt, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    lat_prev   = gp_if.pad_latch;
    have_prev  = 1'b0;
    m_buttons  = 16'h0000;
    m_present  = 1'b0;
    m_prev_raw = 16'h0000;
  endtask

  initial begin
    logic [15:0] r;
    int          sel;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    lat_prev = gp_if.pad_latch;

    run_frame(16'hFFFE);
    check_eq("latch_after_rst", last_wait, 1);
    run_frame(16'hFFFE);
    run_frame(16'hFFE7);
    check_eq("btn_start", gp_if.buttons[BTN_START], m_buttons[BTN_START]);
    check_eq("btn_up", gp_if.buttons[BTN_UP], m_buttons[BTN_UP]);
    run_frame(16'hFFE7);
    run_frame(16'h0000);
    run_frame(16'h0000);

    abort_frame(16'h0F0F);
    run_frame(16'hFFFE);
    check_eq("latch_after_abort", last_wait, 1);

    // Debounce-oriented sequence; the model decides which frames strobe
    run_frame(16'hFFFE);
    run_frame(16'hFFFE);
    run_frame(16'hFFFD);
    run_frame(16'hFFFE);

    r = 16'hFFFE;
    for (int i = 0; i < 10; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       r = r;
        1:       r = 16'h0000;
        2:       r = {4'hF, 12'($urandom)};
        default: r = 16'($urandom);
      endcase
      run_frame(r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
